reg_universal_nb: RTL and testbench

- Parametrised universal register; successor to the fixed 4-bit parallel-in/parallel-out register built from D flip-flops with reset.
- Adds clock enable, parallel load, shift left/right with serial in/out, rotate, and synchronous clear.
- Adds a shift counter that flags when a loaded word has been fully shifted out.
- Used as the data/serialiser register in the datapath labs.

---
 rtl/reg_universal_nb.sv | 95 +++++++++
 tb/tb_reg_universal_nb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_universal_nb.sv
// rtl/reg_universal_nb.sv - parametrised universal register with load, shift, rotate, clear and drain counter
module reg_universal_nb #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [2:0]                     mode,
    input  logic [WIDTH-1:0]               D,
    input  logic                           sin_r,
    input  logic                           sin_l,
    output logic [WIDTH-1:0]               Q,
    output logic                           sout_l,
    output logic                           sout_r,
    output logic [$clog2(WIDTH+1)-1:0]     shift_cnt,
    output logic                           drained
);

    localparam int             CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             drained_q, drained_d;
    logic             shifting;

    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        shifting = 1'b0;
        if (en) begin
            case (mode)
                M_HOLD: ;
                M_LOAD: begin
                    q_d   = D;
                    cnt_d = '0;
                end
                M_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], sin_r};
                    shifting = 1'b1;
                end
                M_SHR: begin
                    q_d      = {sin_l, q_q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                M_ROL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    shifting = 1'b1;
                end
                M_ROR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                M_CLR: begin
                    q_d   = '0;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        // Counter saturates at WIDTH so drained stays up until the next load or clear.
        if (shifting && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        drained_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q       <= RST_VAL;
            cnt_q     <= '0;
            drained_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            drained_q <= drained_d;
        end
    end

    assign Q         = q_q;
    assign sout_l    = q_q[WIDTH-1];
    assign sout_r    = q_q[0];
    assign shift_cnt = cnt_q;
    assign drained   = drained_q;

endmodule

// File: tb/tb_reg_universal_nb.sv
// tb/tb_reg_universal_nb.sv - bench for reg_universal_nb at WIDTH=4 and WIDTH=8
module tb_reg_universal_nb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_en = 1'b0, a_sr = 1'b0, a_sl = 1'b0;
    logic [2:0] a_mode = 3'd0;
    logic [3:0] a_d = 4'd0;
    logic [3:0] a_q;
    logic       a_so_l, a_so_r, a_drn;
    logic [2:0] a_cnt;

    logic       b_en = 1'b0, b_sr = 1'b0, b_sl = 1'b0;
    logic [2:0] b_mode = 3'd0;
    logic [7:0] b_d = 8'd0;
    logic [7:0] b_q;
    logic       b_so_l, b_so_r, b_drn;
    logic [3:0] b_cnt;

    reg_universal_nb #(.WIDTH(4), .RST_VAL(4'h0)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .D(a_d),
        .sin_r(a_sr), .sin_l(a_sl), .Q(a_q), .sout_l(a_so_l), .sout_r(a_so_r),
        .shift_cnt(a_cnt), .drained(a_drn)
    );

    reg_universal_nb #(.WIDTH(8), .RST_VAL(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .D(b_d),
        .sin_r(b_sr), .sin_l(b_sl), .Q(b_q), .sout_l(b_so_l), .sout_r(b_so_r),
        .shift_cnt(b_cnt), .drained(b_drn)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Arithmetic reference: words as integers, shifts as multiply/divide modulo 2**w.
    function automatic void mstep(input int w, input logic e, input logic [2:0] m, input int d,
                                  input logic sr, input logic sl, input int qi, input int ci,
                                  output int qo, output int co);
        int full, half;
        full = 1 << w;
        half = full / 2;
        qo = qi;
        co = ci;
        if (e) begin
            case (m)
                3'd1: begin qo = d; co = 0; end
                3'd2: qo = (qi * 2 + int'(sr)) % full;
                3'd3: qo = qi / 2 + int'(sl) * half;
                3'd4: qo = (qi * 2) % full + qi / half;
                3'd5: qo = qi / 2 + (qi % 2) * half;
                3'd6: begin qo = 0; co = 0; end
                default: ;
            endcase
            if (m >= 3'd2 && m <= 3'd5) co = (ci < w) ? ci + 1 : w;
        end
    endfunction

    int ma_q = 0, ma_c = 0, mb_q = 'hA5, mb_c = 0;

    always @(posedge clk or negedge rst) begin
        int nq, nc;
        if (!rst) begin
            ma_q = 0;    ma_c = 0;
            mb_q = 'hA5; mb_c = 0;
        end else begin
            mstep(4, a_en, a_mode, int'(a_d), a_sr, a_sl, ma_q, ma_c, nq, nc);
            ma_q = nq; ma_c = nc;
            mstep(8, b_en, b_mode, int'(b_d), b_sr, b_sl, mb_q, mb_c, nq, nc);
            mb_q = nq; mb_c = nc;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_a_q",     32'(a_q),    32'(ma_q));
            chk("m_a_cnt",   32'(a_cnt),  32'(ma_c));
            chk("m_a_drn",   32'(a_drn),  32'(ma_c == 4));
            chk("m_a_soutl", 32'(a_so_l), 32'((ma_q >> 3) & 1));
            chk("m_a_soutr", 32'(a_so_r), 32'(ma_q & 1));
            chk("m_b_q",     32'(b_q),    32'(mb_q));
            chk("m_b_cnt",   32'(b_cnt),  32'(mb_c));
            chk("m_b_drn",   32'(b_drn),  32'(mb_c == 8));
        end
    end

    task automatic sa(input logic e, input logic [2:0] m, input logic [3:0] d, input logic sr, input logic sl);
        a_en = e; a_mode = m; a_d = d; a_sr = sr; a_sl = sl;
        @(posedge clk);
        #1;
    endtask

    task automatic sb(input logic e, input logic [2:0] m, input logic [7:0] d, input logic sr, input logic sl);
        b_en = e; b_mode = m; b_d = d; b_sr = sr; b_sl = sl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] qs[4];
        logic       bits[4];

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_q", 32'(a_q), 32'h0);
        chk("rst_b_q", 32'(b_q), 32'hA5);
        rst = 1'b1;
        cmp_on = 1'b1;

        sa(1, 3'd1, 4'b1011, 0, 0);
        chk("load_a", 32'(a_q), 32'hB);
        #2 rst = 1'b0;
        #1;
        chk("async_q",   32'(a_q),   32'h0);
        chk("async_cnt", 32'(a_cnt), 32'h0);
        chk("async_drn", 32'(a_drn), 32'h0);
        a_en = 1'b1; a_mode = 3'd1; a_d = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_q", 32'(a_q), 32'h0);
        end
        rst = 1'b1;

        sa(1, 3'd1, 4'b1011, 0, 0);
        qs = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
        bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            chk("shl_soutl", 32'(a_so_l), 32'(bits[i]));
            sa(1, 3'd2, 4'd0, 0, 0);
            chk("shl_q",   32'(a_q),   32'(qs[i]));
            chk("shl_cnt", 32'(a_cnt), 32'(i + 1));
        end
        chk("shl_drn", 32'(a_drn), 32'h1);
        sa(1, 3'd2, 4'd0, 0, 0);
        chk("shl_sat_cnt", 32'(a_cnt), 32'h4);
        chk("shl_sat_drn", 32'(a_drn), 32'h1);

        sa(1, 3'd1, 4'b0000, 0, 0);
        chk("load_clr_drn", 32'(a_drn), 32'h0);
        bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            chk("shr_soutr", 32'(a_so_r), 32'h0);
            sa(1, 3'd3, 4'd0, 0, bits[i]);
        end
        chk("shr_q", 32'(a_q), 32'b1101);

        sa(1, 3'd1, 4'b1011, 0, 0);
        qs = '{4'b1101, 4'b1110, 4'b0111, 4'b1011};
        for (int i = 0; i < 4; i++) begin
            sa(1, 3'd5, 4'd0, 0, 0);
            chk("ror_q", 32'(a_q), 32'(qs[i]));
        end
        chk("ror_drn", 32'(a_drn), 32'h1);
        sa(1, 3'd4, 4'd0, 0, 0);
        chk("rol_q", 32'(a_q), 32'b0111);

        sa(1, 3'd1, 4'b1011, 0, 0);
        sa(1, 3'd5, 4'd0, 0, 0);
        sa(1, 3'd1, 4'b1011, 0, 0);
        for (int i = 0; i < 2; i++) begin
            sa(0, 3'd1, 4'b0101, 0, 0);
            chk("en0_q",   32'(a_q),   32'hB);
            chk("en0_cnt", 32'(a_cnt), 32'h0);
        end
        sa(0, 3'd2, 4'd0, 1, 0);
        chk("en0_shift_q", 32'(a_q), 32'hB);
        sa(1, 3'd6, 4'd0, 0, 0);
        chk("clr_q",   32'(a_q),   32'h0);
        chk("clr_cnt", 32'(a_cnt), 32'h0);
        sa(1, 3'd7, 4'd0, 0, 0);
        chk("rsv_q", 32'(a_q), 32'h0);

        chk("b_rst_q", 32'(b_q), 32'hA5);
        for (int i = 0; i < 8; i++) sb(1, 3'd2, 8'd0, 1, 0);
        chk("b_q",   32'(b_q),   32'hFF);
        chk("b_cnt", 32'(b_cnt), 32'h8);
        chk("b_drn", 32'(b_drn), 32'h1);
        sb(1, 3'd2, 8'd0, 0, 0);
        chk("b_sat_cnt", 32'(b_cnt), 32'h8);
        chk("b_q2",      32'(b_q),   32'hFE);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
